// File: rtl/blast_pkg.sv
// blast_pkg: shared geometry, nucleotide encoding and streamer states
// for the BLAST database front-end.
package blast_pkg;

    localparam int SYM_W     = 2;
    localparam int WMER_SYMS = 11;
    localparam int WMER_W    = WMER_SYMS * SYM_W;
    localparam int WORD_W    = 512;
    localparam int WORD_SYMS = WORD_W / SYM_W;
    localparam int BUF_W     = 2 * WORD_W;
    localparam int FILL_W    = 10;

    typedef enum logic [1:0] {
        NUC_A = 2'b00,
        NUC_C = 2'b01,
        NUC_G = 2'b10,
        NUC_T = 2'b11
    } nucleotideT;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } streamStateT;

endpackage

// File: rtl/db_wmer_streamer.sv
// db_wmer_streamer: turns packed 512-bit database words into a
// sliding 11-nucleotide w-mer stream, one symbol advance per beat.
// Ports: clk, rst (async, active-low);
//   in_data/in_valid/in_last/in_ready  database word input;
//   wmer/wmer_pos/wmer_valid/wmer_ready  w-mer output;
//   done  one-cycle end-of-database pulse.
// Build option DB_PERF_CNT_EN adds stall_cnt/starve_cnt outputs.
module db_wmer_streamer
    import blast_pkg::*;
#(
    parameter int POS_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [WMER_W-1:0] wmer,
    output logic              wmer_valid,
    input  logic              wmer_ready,
    output logic [POS_W-1:0]  wmer_pos,
    output logic              done
`ifdef DB_PERF_CNT_EN
    ,
    output logic [POS_W-1:0]  stall_cnt,
    output logic [POS_W-1:0]  starve_cnt
`endif
);

    streamStateT       state;
    streamStateT       stateNext;
    logic [BUF_W-1:0]  symBuf;
    logic [BUF_W-1:0]  symBufNext;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fillNext;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  posNext;
    logic              validQ;
    logic              validNext;

    logic              xfer;
    logic              beat;
    logic [FILL_W-1:0] remain;
    logic [FILL_W:0]   shamt;
    logic [BUF_W-1:0]  shifted;
    logic [BUF_W-1:0]  appended;

    // Gated by rst so the port reads 0 while reset is held.
    assign in_ready = rst
                   && (state == IDLE || state == STREAM)
                   && (fill <= FILL_W'(WORD_SYMS));

    assign xfer = in_valid && in_ready;
    assign beat = validQ && wmer_ready;

    // Oldest symbol sits in the buffer MSBs.
    assign wmer       = symBuf[BUF_W-1 -: WMER_W];
    assign wmer_valid = validQ;
    assign wmer_pos   = pos;
    assign done       = (state == DONE);

    always_comb begin
        remain   = fill - FILL_W'(beat);
        shifted  = beat ? (symBuf << SYM_W) : symBuf;
        // Bits below the live symbols are always zero, so the new
        // word can be OR-ed in right behind the surviving symbols.
        shamt    = {remain, 1'b0};
        appended = {in_data, {WORD_W{1'b0}}} >> shamt;

        stateNext  = state;
        symBufNext = shifted;
        fillNext   = remain;
        posNext    = pos + POS_W'(beat);

        if (xfer) begin
            symBufNext = shifted | appended;
            fillNext   = remain + FILL_W'(WORD_SYMS);
        end

        unique case (state)
            IDLE: begin
                if (xfer) begin
                    stateNext = in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (xfer && in_last) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (fillNext <= FILL_W'(WMER_SYMS - 1)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                // Trailing partial window is dropped here.
                stateNext  = IDLE;
                symBufNext = '0;
                fillNext   = '0;
                posNext    = '0;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        validNext = (fillNext >= FILL_W'(WMER_SYMS));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            symBuf <= '0;
            fill   <= '0;
            pos    <= '0;
            validQ <= 1'b0;
        end else begin
            state  <= stateNext;
            symBuf <= symBufNext;
            fill   <= fillNext;
            pos    <= posNext;
            validQ <= validNext;
        end
    end

`ifdef DB_PERF_CNT_EN
    logic [POS_W-1:0] stallQ;
    logic [POS_W-1:0] starveQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallQ  <= '0;
            starveQ <= '0;
        end else if (state == DONE) begin
            stallQ  <= '0;
            starveQ <= '0;
        end else begin
            if (validQ && !wmer_ready && stallQ != '1) begin
                stallQ <= stallQ + 1'b1;
            end
            if (state == STREAM && !validQ && starveQ != '1) begin
                starveQ <= starveQ + 1'b1;
            end
        end
    end

    assign stall_cnt  = stallQ;
    assign starve_cnt = starveQ;
`endif

endmodule

// File: tb/tb_db_wmer_streamer.sv
// tb_db_wmer_streamer: randomized bench for db_wmer_streamer with a
// symbol-array reference model checked every cycle.
`timescale 1ns/1ps
module tb_db_wmer_streamer;
    import blast_pkg::*;

    localparam int POS_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [WMER_W-1:0] wmer;
    logic              wmer_valid;
    logic              wmer_ready = 1'b1;
    logic [POS_W-1:0]  wmer_pos;
    logic              done;
`ifdef DB_PERF_CNT_EN
    logic [POS_W-1:0]  stall_cnt;
    logic [POS_W-1:0]  starve_cnt;
`endif

    db_wmer_streamer #(.POS_W(POS_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .wmer       (wmer),
        .wmer_valid (wmer_valid),
        .wmer_ready (wmer_ready),
        .wmer_pos   (wmer_pos),
        .done       (done)
`ifdef DB_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .starve_cnt (starve_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         nCmp = 0;
    int         nFail = 0;
    logic [1:0] dbSyms [0:4095];
    int         wrPtr = 0;
    int         recv = 0;
    int         cons = 0;
    bit         lastAcc = 1'b0;
    int         doneCnt = 0;
    int         beatsAtDone = 0;
    int         litMode = 0;
    int         readyMode = 0;
    int         stallM = 0;
    int         starveM = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [WMER_W-1:0] modelWmer(input int p);
        logic [WMER_W-1:0] w;
        w = '0;
        for (int k = 0; k < WMER_SYMS; k++) begin
            w = {w[WMER_W-SYM_W-1:0], dbSyms[p+k]};
        end
        return w;
    endfunction

    // Reference: fill is symbols received minus symbols consumed.
    always @(negedge clk) begin
        if (rst) begin
            int fillM;
            bit expV;
            bit expD;
            bit expR;
            fillM = recv - cons;
            expV  = fillM >= WMER_SYMS;
            expD  = lastAcc && (fillM == WMER_SYMS - 1);
            expR  = !lastAcc && (fillM <= WORD_SYMS);
            chk("wmer_valid", wmer_valid, expV);
            chk("in_ready", in_ready, expR);
            chk("done", done, expD);
            if (expV && wmer_valid) begin
                chk("wmer_pos", wmer_pos, cons);
                chk("wmer", wmer, modelWmer(cons));
                if (litMode == 1 && cons == 0)
                    chk("first_wmer", wmer, 22'h06C6C6);
                if (litMode == 2 && cons == 250)
                    chk("pos250_wmer", wmer, 22'h0003FF);
            end
            if (wmer_valid && !wmer_ready) stallM++;
            if (recv > 0 && !lastAcc && !wmer_valid) starveM++;
            if (done) begin
`ifdef DB_PERF_CNT_EN
                chk("stall_cnt", stall_cnt, stallM);
                chk("starve_cnt", starve_cnt, starveM);
`endif
                beatsAtDone = cons;
                doneCnt++;
                recv    = 0;
                cons    = 0;
                lastAcc = 1'b0;
                stallM  = 0;
                starveM = 0;
            end else begin
                if (in_valid && in_ready) begin
                    recv += WORD_SYMS;
                    if (in_last) lastAcc = 1'b1;
                end
                if (wmer_valid && wmer_ready) cons++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       wmer_ready = 1'b1;
                1:       wmer_ready = ~wmer_ready;
                default: wmer_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic makeWord(input int kind,
                            output logic [WORD_W-1:0] w);
        logic [1:0] s;
        w = '0;
        for (int i = 0; i < WORD_SYMS; i++) begin
            case (kind)
                0:       s = 2'(i % 4);
                1:       s = 2'b00;
                2:       s = 2'b11;
                default: s = 2'($urandom_range(0, 3));
            endcase
            w[WORD_W-1-SYM_W*i -: SYM_W] = s;
            dbSyms[wrPtr] = s;
            wrPtr++;
        end
    endtask

    task automatic sendWord(input int kind, input bit last);
        logic [WORD_W-1:0] w;
        int budget;
        makeWord(kind, w);
        in_data  = w;
        in_valid = 1'b1;
        in_last  = last;
        budget   = 0;
        @(negedge clk);
        while (!in_ready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = {WORD_W{1'b1}};
    endtask

    task automatic waitDone(input int expBeats);
        int start;
        int budget;
        start  = doneCnt;
        budget = 0;
        while (doneCnt == start && budget < 5000) begin
            @(posedge clk);
            budget++;
        end
        chk("done_seen", doneCnt != start, 1);
        chk("beats", beatsAtDone, expBeats);
        @(posedge clk);
        #1;
        wrPtr = 0;
    endtask

    task automatic waitCons(input int n);
        int budget;
        budget = 0;
        while (cons < n && budget < 5000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        chk("cons_reached", cons >= n, 1);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_wmer", wmer, 0);
        chk("rst_valid", wmer_valid, 0);
        chk("rst_pos", wmer_pos, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single word, repeating ACGT.
        litMode = 1;
        sendWord(0, 1'b1);
        waitDone(246);

        // All-A then all-T, back to back.
        litMode = 2;
        sendWord(1, 1'b0);
        sendWord(2, 1'b1);
        waitDone(502);

        // Toggling ready over two random words.
        litMode   = 0;
        readyMode = 1;
        sendWord(3, 1'b0);
        sendWord(3, 1'b1);
        waitDone(502);

        // Toggling ready on one word.
        sendWord(0, 1'b1);
        waitDone(246);

        // Starvation between words.
        readyMode = 0;
        sendWord(3, 1'b0);
        waitCons(246);
        repeat (20) @(posedge clk);
        #1;
        sendWord(3, 1'b1);
        @(negedge clk);
        chk("resume_valid", wmer_valid, 1);
        chk("resume_pos", wmer_pos, 246);
        waitDone(502);

        // Async reset mid-stream.
        sendWord(0, 1'b1);
        waitCons(100);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_wmer", wmer, 0);
        chk("mid_rst_valid", wmer_valid, 0);
        chk("mid_rst_pos", wmer_pos, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", in_ready, 0);
        recv    = 0;
        cons    = 0;
        lastAcc = 1'b0;
        stallM  = 0;
        starveM = 0;
        wrPtr   = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        litMode = 1;
        sendWord(0, 1'b1);
        @(negedge clk);
        chk("post_rst_pos", wmer_pos, 0);
        waitDone(246);

        // Random databases, gaps and backpressure.
        litMode   = 0;
        readyMode = 2;
        for (int r = 0; r < 3; r++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int k = 0; k < nw; k++) begin
                int gap;
                gap = $urandom_range(0, 30);
                for (int g = 0; g < gap; g++) begin
                    in_last = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                sendWord(3, k == nw - 1);
            end
            waitDone(nw * WORD_SYMS - (WMER_SYMS - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nFail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
